// File: rtl/pic_inta_sequencer_if.sv
// CPU-side acknowledge bus of the interrupt controller: INTA strobe in,
// INT request, vector byte and drive enable out.
interface pic_inta_sequencer_if;
  logic       inta_n;
  logic       int_out;
  logic [7:0] data_out;
  logic       data_out_en;
  logic       ack_busy;

  modport master (
    output inta_n,
    input  int_out,
    input  data_out,
    input  data_out_en,
    input  ack_busy
  );

  modport slave (
    input  inta_n,
    output int_out,
    output data_out,
    output data_out_en,
    output ack_busy
  );
endinterface

// File: rtl/pic_inta_sequencer.sv
// Acknowledge side of an 8259A-style controller: INT/INTA handshake, ISR
// ownership, vector output, EOI handling and priority rotation.
module pic_inta_sequencer #(
  parameter logic [2:0] RESET_ROTATE   = 3'd0,
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              interrupt,
  input  logic [4:0]              vector_base,
  input  logic                    auto_eoi,
  input  logic                    rotate_on_aeoi,
  input  logic                    nonspec_eoi,
  input  logic                    spec_eoi,
  input  logic [2:0]              eoi_level,
  input  logic                    rotate_on_eoi,
  input  logic                    set_priority,
  input  logic [2:0]              priority_level,
  output logic [7:0]              isr,
  output logic [7:0]              clear_irr,
  output logic [2:0]              priority_rotate,
  output logic [7:0]              highest_level_in_service,
  pic_inta_sequencer_if.slave     cpu
);

  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;

  state_t     state, state_next;
  logic       prev_inta_n;
  logic       fall, rise;
  logic [2:0] level_q, level_next;
  logic       spurious_q, spurious_next;
  logic       int_out_q, int_out_next;
  logic [7:0] data_out_q, data_out_next;
  logic       data_out_en_q, data_out_en_next;
  logic [7:0] isr_next, isr_set, isr_clr;
  logic [7:0] clear_irr_next;
  logic [2:0] rotate_next;
  logic [2:0] eoi_lvl;
  logic       eoi_valid;
  logic       aeoi_rot;
  logic [2:0] scan_idx;
  logic       scan_found;

  function automatic logic [2:0] onehot_to_level(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++)
      if (v[i]) r = 3'(i);
    return r;
  endfunction

  assign fall = prev_inta_n & ~cpu.inta_n;
  assign rise = ~prev_inta_n & cpu.inta_n;

  // Walk levels starting at the rotation point; the first set ISR bit wins.
  always_comb begin
    highest_level_in_service = 8'h00;
    scan_found = 1'b0;
    scan_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      scan_idx = priority_rotate + 3'(i);
      if (!scan_found && isr[scan_idx]) begin
        highest_level_in_service[scan_idx] = 1'b1;
        scan_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next       = state;
    level_next       = level_q;
    spurious_next    = spurious_q;
    int_out_next     = 1'b0;
    data_out_next    = data_out_q;
    data_out_en_next = 1'b0;
    clear_irr_next   = 8'h00;
    isr_set          = 8'h00;
    isr_clr          = 8'h00;
    aeoi_rot         = 1'b0;
    eoi_lvl          = 3'd0;
    eoi_valid        = 1'b0;
    rotate_next      = priority_rotate;

    unique case (state)
      IDLE: begin
        int_out_next = |interrupt;
        if (fall) begin
          if (interrupt != 8'h00) begin
            level_next     = onehot_to_level(interrupt);
            spurious_next  = 1'b0;
            isr_set        = interrupt;
            clear_irr_next = interrupt;
          end else begin
            spurious_next  = 1'b1;
          end
          int_out_next = 1'b0;
          state_next   = ACK1;
        end
      end
      ACK1: begin
        if (rise) state_next = WAIT2;
      end
      WAIT2: begin
        if (fall) state_next = ACK2;
      end
      ACK2: begin
        data_out_next    = {vector_base, spurious_q ? SPURIOUS_LEVEL : level_q};
        data_out_en_next = 1'b1;
        if (rise) begin
          data_out_en_next = 1'b0;
          state_next       = IDLE;
          if (auto_eoi && !spurious_q) begin
            isr_clr[level_q] = 1'b1;
            aeoi_rot         = rotate_on_aeoi;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Specific EOI takes precedence over non-specific in the same cycle.
    if (spec_eoi) begin
      isr_clr[eoi_level] = 1'b1;
      eoi_lvl   = eoi_level;
      eoi_valid = 1'b1;
    end else if (nonspec_eoi && (highest_level_in_service != 8'h00)) begin
      isr_clr   = isr_clr | highest_level_in_service;
      eoi_lvl   = onehot_to_level(highest_level_in_service);
      eoi_valid = 1'b1;
    end

    isr_next = (isr & ~isr_clr) | isr_set;

    if (aeoi_rot)                   rotate_next = level_q + 3'd1;
    if (eoi_valid && rotate_on_eoi) rotate_next = eoi_lvl + 3'd1;
    if (set_priority)               rotate_next = priority_level + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      prev_inta_n     <= 1'b1;
      level_q         <= 3'd0;
      spurious_q      <= 1'b0;
      int_out_q       <= 1'b0;
      data_out_q      <= 8'h00;
      data_out_en_q   <= 1'b0;
      isr             <= 8'h00;
      clear_irr       <= 8'h00;
      priority_rotate <= RESET_ROTATE;
    end else begin
      state           <= state_next;
      prev_inta_n     <= cpu.inta_n;
      level_q         <= level_next;
      spurious_q      <= spurious_next;
      int_out_q       <= int_out_next;
      data_out_q      <= data_out_next;
      data_out_en_q   <= data_out_en_next;
      isr             <= isr_next;
      clear_irr       <= clear_irr_next;
      priority_rotate <= rotate_next;
    end
  end

  assign cpu.int_out     = int_out_q;
  assign cpu.data_out    = data_out_q;
  assign cpu.data_out_en = data_out_en_q;
  assign cpu.ack_busy    = (state != IDLE);

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Bench for pic_inta_sequencer: scenario tasks plus a vector scoreboard
// that checks every byte the sequencer drives onto the bus.
module tb_pic_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] interrupt;
  logic [4:0] vector_base;
  logic       auto_eoi, rotate_on_aeoi, nonspec_eoi, spec_eoi, rotate_on_eoi, set_priority;
  logic [2:0] eoi_level, priority_level;
  logic [7:0] isr, clear_irr, hlis;
  logic [2:0] priority_rotate;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];
  logic       en_seen = 1'b0;

  pic_inta_sequencer_if bus();

  pic_inta_sequencer #(.RESET_ROTATE(3'd0), .SPURIOUS_LEVEL(3'd7)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .interrupt                (interrupt),
    .vector_base              (vector_base),
    .auto_eoi                 (auto_eoi),
    .rotate_on_aeoi           (rotate_on_aeoi),
    .nonspec_eoi              (nonspec_eoi),
    .spec_eoi                 (spec_eoi),
    .eoi_level                (eoi_level),
    .rotate_on_eoi            (rotate_on_eoi),
    .set_priority             (set_priority),
    .priority_level           (priority_level),
    .isr                      (isr),
    .clear_irr                (clear_irr),
    .priority_rotate          (priority_rotate),
    .highest_level_in_service (hlis),
    .cpu                      (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard: compare each new vector drive against the oldest expectation.
  always @(negedge clk) begin
    if (bus.data_out_en === 1'b1 && !en_seen) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL vector_unexpected: got %h with no vector expected", bus.data_out);
      end else begin
        logic [7:0] exp_v;
        exp_v = exp_q.pop_front();
        if (bus.data_out !== exp_v) begin
          tests_failed++;
          $display("FAIL vector: got %h expected %h", bus.data_out, exp_v);
        end
      end
    end
    en_seen = (bus.data_out_en === 1'b1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Second INTA pulse: fall into ACK2, hold one cycle for the vector, release.
  task automatic finish_ack();
    bus.inta_n = 1'b0; tick();
    tick();
    bus.inta_n = 1'b1; tick();
  endtask

  task automatic ack_cycle(input logic [7:0] req, input logic [7:0] vec);
    interrupt = req; tick();
    exp_q.push_back(vec);
    bus.inta_n = 1'b0; tick();
    interrupt = 8'h00;
    bus.inta_n = 1'b1; tick();
    finish_ack();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.inta_n = 1'b1; tick(); tick();
    tests_run++;
    if (isr !== 8'h00 || clear_irr !== 8'h00 || bus.int_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_regs: isr=%h clr=%h int=%b expected 00 00 0", isr, clear_irr, bus.int_out);
    end
    tests_run++;
    if (bus.data_out !== 8'h00 || bus.data_out_en !== 1'b0 || bus.ack_busy !== 1'b0 ||
        priority_rotate !== 3'd0 || hlis !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_bus: dout=%h en=%b busy=%b rot=%0d hlis=%h expected 00 0 0 0 00",
               bus.data_out, bus.data_out_en, bus.ack_busy, priority_rotate, hlis);
    end
    rst_n = 1'b1; tick();
  endtask

  task automatic test_basic_ack();
    vector_base = 5'h10;
    interrupt = 8'h08; tick();
    tests_run++;
    if (bus.int_out !== 1'b1) begin
      tests_failed++; $display("FAIL int_out_raise: got %b expected 1", bus.int_out);
    end
    exp_q.push_back(8'h83);
    bus.inta_n = 1'b0; tick();
    tests_run++;
    if (clear_irr !== 8'h08 || isr !== 8'h08 || bus.int_out !== 1'b0 || bus.ack_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL first_fall: clr=%h isr=%h int=%b busy=%b expected 08 08 0 1",
               clear_irr, isr, bus.int_out, bus.ack_busy);
    end
    interrupt = 8'h00; tick();
    tests_run++;
    if (clear_irr !== 8'h00) begin
      tests_failed++; $display("FAIL clear_irr_pulse: got %h expected 00", clear_irr);
    end
    bus.inta_n = 1'b1; tick();
    finish_ack();
    tests_run++;
    if (bus.ack_busy !== 1'b0 || isr !== 8'h08 || bus.data_out_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_release: busy=%b isr=%h en=%b expected 0 08 0", bus.ack_busy, isr, bus.data_out_en);
    end
  endtask

  task automatic test_aeoi_rotate();
    spec_eoi = 1'b1; eoi_level = 3'd3; tick();
    spec_eoi = 1'b0;
    tests_run++;
    if (isr !== 8'h00 || priority_rotate !== 3'd0) begin
      tests_failed++; $display("FAIL spec_eoi_clear: isr=%h rot=%0d expected 00 0", isr, priority_rotate);
    end
    auto_eoi = 1'b1; rotate_on_aeoi = 1'b1;
    interrupt = 8'h04; tick();
    exp_q.push_back(8'h82);
    bus.inta_n = 1'b0; tick();
    tests_run++;
    if (isr !== 8'h04) begin
      tests_failed++; $display("FAIL aeoi_set: isr=%h expected 04", isr);
    end
    interrupt = 8'h00;
    bus.inta_n = 1'b1; tick();
    finish_ack();
    tests_run++;
    if (isr !== 8'h00 || priority_rotate !== 3'd3) begin
      tests_failed++; $display("FAIL aeoi_release: isr=%h rot=%0d expected 00 3", isr, priority_rotate);
    end
    auto_eoi = 1'b0; rotate_on_aeoi = 1'b0;
  endtask

  task automatic test_spurious();
    interrupt = 8'h04; tick();
    interrupt = 8'h00;
    bus.inta_n = 1'b0; tick();
    exp_q.push_back(8'h87);
    tests_run++;
    if (clear_irr !== 8'h00 || isr !== 8'h00 || bus.ack_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL spurious_fall: clr=%h isr=%h busy=%b expected 00 00 1", clear_irr, isr, bus.ack_busy);
    end
    bus.inta_n = 1'b1; tick();
    finish_ack();
    tests_run++;
    if (isr !== 8'h00 || bus.ack_busy !== 1'b0) begin
      tests_failed++; $display("FAIL spurious_end: isr=%h busy=%b expected 00 0", isr, bus.ack_busy);
    end
  endtask

  task automatic test_nonspec_eoi_rotate();
    set_priority = 1'b1; priority_level = 3'd6; tick();
    set_priority = 1'b0;
    tests_run++;
    if (priority_rotate !== 3'd7) begin
      tests_failed++; $display("FAIL set_priority: rot=%0d expected 7", priority_rotate);
    end
    ack_cycle(8'h01, 8'h80);
    ack_cycle(8'h80, 8'h87);
    tests_run++;
    if (isr !== 8'h81 || hlis !== 8'h80) begin
      tests_failed++; $display("FAIL nested_isr: isr=%h hlis=%h expected 81 80", isr, hlis);
    end
    nonspec_eoi = 1'b1; rotate_on_eoi = 1'b1; tick();
    nonspec_eoi = 1'b0; rotate_on_eoi = 1'b0;
    tests_run++;
    if (isr !== 8'h01 || priority_rotate !== 3'd0 || hlis !== 8'h01) begin
      tests_failed++;
      $display("FAIL nonspec_rotate: isr=%h rot=%0d hlis=%h expected 01 0 01", isr, priority_rotate, hlis);
    end
  endtask

  task automatic test_simultaneous();
    interrupt = 8'h04; tick();
    exp_q.push_back(8'h82);
    bus.inta_n = 1'b0; spec_eoi = 1'b1; eoi_level = 3'd2; tick();
    spec_eoi = 1'b0; interrupt = 8'h00;
    tests_run++;
    if (isr !== 8'h05 || clear_irr !== 8'h04) begin
      tests_failed++; $display("FAIL set_beats_clear: isr=%h clr=%h expected 05 04", isr, clear_irr);
    end
    bus.inta_n = 1'b1; tick();
    finish_ack();
    spec_eoi = 1'b1; nonspec_eoi = 1'b1; eoi_level = 3'd2; tick();
    spec_eoi = 1'b0; nonspec_eoi = 1'b0;
    tests_run++;
    if (isr !== 8'h01) begin
      tests_failed++; $display("FAIL spec_beats_nonspec: isr=%h expected 01", isr);
    end
    spec_eoi = 1'b1; eoi_level = 3'd0; tick();
    spec_eoi = 1'b0;
    set_priority = 1'b1; priority_level = 3'd3; tick();
    set_priority = 1'b0;
    nonspec_eoi = 1'b1; rotate_on_eoi = 1'b1; tick();
    nonspec_eoi = 1'b0; rotate_on_eoi = 1'b0;
    tests_run++;
    if (isr !== 8'h00 || priority_rotate !== 3'd4) begin
      tests_failed++; $display("FAIL empty_nonspec_rotate: isr=%h rot=%0d expected 00 4", isr, priority_rotate);
    end
  endtask

  task automatic test_reset_mid_ack();
    interrupt = 8'h02; tick();
    exp_q.push_back(8'h81);
    bus.inta_n = 1'b0; tick();
    interrupt = 8'h00;
    bus.inta_n = 1'b1; tick();
    bus.inta_n = 1'b0; tick();
    tick();
    tests_run++;
    if (bus.data_out_en !== 1'b1 || bus.ack_busy !== 1'b1) begin
      tests_failed++; $display("FAIL ack2_entry: en=%b busy=%b expected 1 1", bus.data_out_en, bus.ack_busy);
    end
    rst_n = 1'b0; bus.inta_n = 1'b1; tick();
    tests_run++;
    if (bus.data_out_en !== 1'b0 || bus.ack_busy !== 1'b0 || isr !== 8'h00 || priority_rotate !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_in_ack2: en=%b busy=%b isr=%h rot=%0d expected 0 0 00 0",
               bus.data_out_en, bus.ack_busy, isr, priority_rotate);
    end
    rst_n = 1'b1; tick(); tick(); tick();
    tests_run++;
    if (bus.data_out_en !== 1'b0 || bus.ack_busy !== 1'b0) begin
      tests_failed++; $display("FAIL after_reset_idle: en=%b busy=%b expected 0 0", bus.data_out_en, bus.ack_busy);
    end
  endtask

  initial begin
    rst_n = 1'b0; bus.inta_n = 1'b1; interrupt = 8'h00; vector_base = 5'h10;
    auto_eoi = 1'b0; rotate_on_aeoi = 1'b0; nonspec_eoi = 1'b0; spec_eoi = 1'b0;
    eoi_level = 3'd0; rotate_on_eoi = 1'b0; set_priority = 1'b0; priority_level = 3'd0;
    test_reset();
    test_basic_ack();
    test_aeoi_rotate();
    test_spurious();
    test_nonspec_eoi_rotate();
    test_simultaneous();
    test_reset_mid_ack();
    tick();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL vectors_outstanding: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pic_inta_sequencer.md
Name: pic_inta_sequencer

Overview:
- CPU-facing acknowledge side of the 8259A-style controller; consumes the one-hot `interrupt` request produced by the priority resolver.
- Drives INT to the CPU and runs the two-pulse (8086-mode) INTA sequence.
- Owns the ISR register, issues IRR-clear pulses and puts the vector on the data bus.
- Handles EOI commands (specific, non-specific, automatic) and priority rotation; its `isr`, `priority_rotate` and `highest_level_in_service` outputs feed back into the resolver.

Parameters:
- RESET_ROTATE, 3'd0, reset value of `priority_rotate`; level RESET_ROTATE is highest priority.
- SPURIOUS_LEVEL, 3'd7, level code placed in the vector when an acknowledge finds no request.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- interrupt  in  8  one-hot (or zero) winning request from the priority resolver.
- inta_n  in  1  CPU acknowledge strobe, active low, synchronous to clk.
- vector_base  in  5  ICW2 T7..T3.
- auto_eoi  in  1  AEOI mode enable.
- rotate_on_aeoi  in  1  rotate priority on automatic EOI.
- nonspec_eoi  in  1  one-cycle non-specific EOI command strobe.
- spec_eoi  in  1  one-cycle specific EOI strobe.
- eoi_level  in  3  level for `spec_eoi`.
- rotate_on_eoi  in  1  qualifies either EOI strobe: rotate after clearing.
- set_priority  in  1  one-cycle strobe: load rotation so `priority_level`+1 becomes highest priority.
- priority_level  in  3  operand for `set_priority`.
- int_out  out  1  INT request to CPU.
- isr  out  8  in-service register.
- clear_irr  out  8  one-cycle one-hot pulse clearing the acknowledged IRR bit.
- priority_rotate  out  3  current rotation to resolver.
- highest_level_in_service  out  8  one-hot highest-priority set ISR bit (0 if ISR empty).
- data_out  out  8  vector byte.
- data_out_en  out  1  data bus drive enable.
- ack_busy  out  1  high whenever state != IDLE.

Behaviour:
- All state is registered on clk.
- Reset (rst_n=0 at a clock edge), from any state:
  - state=IDLE; isr=0; clear_irr=0; int_out=0; data_out=0; data_out_en=0.
  - priority_rotate=RESET_ROTATE; internal latched level cleared; inta_n history register set to 1.
  - Reset mid-sequence abandons the acknowledge; no vector is driven afterwards.
- Edge detection: `fall` = prev_inta_n & ~inta_n; `rise` = ~prev_inta_n & inta_n. prev_inta_n is updated every cycle.
- Priority order: rotated index i = (level - priority_rotate) mod 8; smallest i has highest priority.
- `highest_level_in_service` is a combinational decode of `isr` and `priority_rotate`.
- FSM states IDLE, ACK1, WAIT2, ACK2:
  - IDLE: int_out registers |interrupt (1-cycle latency). On `fall`:
    - If interrupt != 0: latch level; isr |= interrupt; clear_irr = interrupt for exactly one cycle.
    - If interrupt == 0: mark spurious; no ISR or IRR change.
    - In both cases go to ACK1 and force int_out=0.
  - ACK1: on `rise` go to WAIT2. data_out_en=0.
  - WAIT2: on `fall` go to ACK2.
  - ACK2:
    - data_out = {vector_base, level}, where level = SPURIOUS_LEVEL if spurious.
    - data_out_en=1 from the cycle after entry until `rise`.
    - On `rise`: data_out_en=0; go to IDLE.
    - If auto_eoi and not spurious: clear the latched ISR bit on that same edge. If rotate_on_aeoi also set: priority_rotate = (level+1) mod 8.
  - int_out=0 in every non-IDLE state.
- EOI handling (processed in any state):
  - nonspec_eoi clears the bit in `highest_level_in_service`; no effect if ISR is empty.
  - spec_eoi clears isr[eoi_level].
  - With rotate_on_eoi set, priority_rotate = (cleared level + 1) mod 8, wrapping 7 -> 0. Non-specific rotate with ISR empty leaves priority_rotate unchanged.
- set_priority: priority_rotate = (priority_level+1) mod 8.
- Simultaneous events, same cycle:
  - ISR set beats ISR clear of the same bit: isr_next = (isr & ~clr) | set.
  - spec_eoi beats nonspec_eoi.
  - Rotation precedence: set_priority, then EOI rotation, then AEOI rotation.
- `interrupt` changing after latch does not affect the vector.
- ISR is multi-bit capable (nested service).

Test Plan:
- Reset, interrupt=8'h08, vector_base=5'h10, auto_eoi=0:
  - int_out=1 one cycle after the request.
  - First INTA fall -> clear_irr=8'h08 for one cycle, isr=8'h08, int_out=0.
  - Second INTA low -> data_out=8'h83, data_out_en=1.
  - Release -> IDLE with isr=8'h08.
- auto_eoi=1, rotate_on_aeoi=1, interrupt=8'h04 through the full sequence -> isr returns to 0 at the second rise; priority_rotate=3.
- interrupt drops to 0 before the first INTA fall -> clear_irr stays 0, isr unchanged, vector = {vector_base,3'd7}.
- isr=8'h81, priority_rotate=7, nonspec_eoi with rotate_on_eoi -> isr=8'h01 (level 7 cleared), priority_rotate=0.
- spec_eoi on level 2 in the same cycle as an acknowledge setting bit 2 -> isr bit 2 remains 1.
- rst_n=0 while in ACK2 -> data_out_en=0, state IDLE, isr=0, priority_rotate=RESET_ROTATE on the next edge.
